// File: rtl/audio_mix_scheduler.sv
// audio_mix_scheduler: once per sample period, fetch one stereo sample from each
// enabled source over valid/ready, mix the samples with saturation and present the
// result to the audio output stage. A source that misses the fetch window is
// treated as silence and flagged as underrun.
module audio_mix_scheduler #(
  parameter int WIDTH   = 16,
  parameter int DIV     = 1134,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [1:0]       src_en,
  input  logic             clear_status,
  input  logic             src0_valid,
  input  logic [WIDTH-1:0] src0_l,
  input  logic [WIDTH-1:0] src0_r,
  output logic             src0_ready,
  input  logic             src1_valid,
  input  logic [WIDTH-1:0] src1_l,
  input  logic [WIDTH-1:0] src1_r,
  output logic             src1_ready,
  output logic [WIDTH-1:0] out_l,
  output logic [WIDTH-1:0] out_r,
  output logic             out_valid,
  output logic [1:0]       underrun,
  output logic [7:0]       underrun_cnt
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [WW-1:0] WC_MAX  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_MIX     = 2'd2,
    ST_PRESENT = 2'd3
  } state_t;

  // Signed add of two samples at WIDTH+1 bits, clamped to the WIDTH-bit range.
  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1]) begin
      sat_add = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sat_add = s[WIDTH-1:0];
    end
  endfunction

  // Add 0..2 events to the 8-bit underrun counter, sticking at 255.
  function automatic logic [7:0] cnt_add(input logic [7:0] base, input logic [1:0] miss);
    logic [8:0] t;
    t = {1'b0, base} + {8'd0, miss[0]} + {8'd0, miss[1]};
    cnt_add = (t > 9'd255) ? 8'hFF : t[7:0];
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]    wc_q, wc_d;
  logic [1:0]       en_q, en_d;
  logic [1:0]       got_q, got_d;
  logic [WIDTH-1:0] s0_l_q, s0_l_d, s0_r_q, s0_r_d;
  logic [WIDTH-1:0] s1_l_q, s1_l_d, s1_r_q, s1_r_d;
  logic [WIDTH-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       underrun_q, underrun_d;
  logic [7:0]       ucnt_q, ucnt_d;
  logic             tick;
  logic             acc0, acc1;
  logic [1:0]       got_now;
  logic [1:0]       miss;

  // Ready is a pure decode of registered state so it drops as soon as reset asserts.
  assign src0_ready = (state_q == ST_FETCH) && en_q[0] && !got_q[0];
  assign src1_ready = (state_q == ST_FETCH) && en_q[1] && !got_q[1];
  assign acc0       = src0_valid && src0_ready;
  assign acc1       = src1_valid && src1_ready;
  assign got_now    = got_q | {acc1, acc0};
  assign miss       = en_q & ~got_q;
  assign tick       = (cnt_q == CNT_MAX) && enable;

  assign out_l        = out_l_q;
  assign out_r        = out_r_q;
  assign out_valid    = out_valid_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;

  // Next-state logic: period counter, fetch/mix sequencing and sticky status.
  always_comb begin
    state_d     = state_q;
    wc_d        = wc_q;
    en_d        = en_q;
    got_d       = got_q;
    s0_l_d      = s0_l_q;
    s0_r_d      = s0_r_q;
    s1_l_d      = s1_l_q;
    s1_r_d      = s1_r_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    out_valid_d = 1'b0;

    if (!enable) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end

    // A clear pulse is applied first so that an underrun set in the same cycle wins.
    if (clear_status) begin
      underrun_d = 2'b00;
      ucnt_d     = 8'd0;
    end else begin
      underrun_d = underrun_q;
      ucnt_d     = ucnt_q;
    end

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            en_d    = src_en;
            got_d   = 2'b00;
            s0_l_d  = {WIDTH{1'b0}};
            s0_r_d  = {WIDTH{1'b0}};
            s1_l_d  = {WIDTH{1'b0}};
            s1_r_d  = {WIDTH{1'b0}};
            wc_d    = {WW{1'b0}};
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FETCH: begin
          got_d = got_now;
          if (acc0) begin
            s0_l_d = src0_l;
            s0_r_d = src0_r;
          end else begin
            s0_l_d = s0_l_q;
          end
          if (acc1) begin
            s1_l_d = src1_l;
            s1_r_d = src1_r;
          end else begin
            s1_l_d = s1_l_q;
          end
          if ((got_now & en_q) == en_q) begin
            state_d = ST_MIX;
          end else if (wc_q == WC_MAX) begin
            state_d = ST_MIX;
          end else begin
            wc_d = wc_q + {{(WW-1){1'b0}}, 1'b1};
          end
        end
        ST_MIX: begin
          out_l_d     = sat_add(got_q[0] ? s0_l_q : {WIDTH{1'b0}},
                                got_q[1] ? s1_l_q : {WIDTH{1'b0}});
          out_r_d     = sat_add(got_q[0] ? s0_r_q : {WIDTH{1'b0}},
                                got_q[1] ? s1_r_q : {WIDTH{1'b0}});
          out_valid_d = 1'b1;
          underrun_d  = underrun_d | miss;
          ucnt_d      = cnt_add(ucnt_d, miss);
          state_d     = ST_PRESENT;
        end
        ST_PRESENT: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset aborts any partial fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      wc_q        <= {WW{1'b0}};
      en_q        <= 2'b00;
      got_q       <= 2'b00;
      s0_l_q      <= {WIDTH{1'b0}};
      s0_r_q      <= {WIDTH{1'b0}};
      s1_l_q      <= {WIDTH{1'b0}};
      s1_r_q      <= {WIDTH{1'b0}};
      out_l_q     <= {WIDTH{1'b0}};
      out_r_q     <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      underrun_q  <= 2'b00;
      ucnt_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wc_q        <= wc_d;
      en_q        <= en_d;
      got_q       <= got_d;
      s0_l_q      <= s0_l_d;
      s0_r_q      <= s0_r_d;
      s1_l_q      <= s1_l_d;
      s1_r_q      <= s1_r_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
      ucnt_q      <= ucnt_d;
    end
  end

endmodule
